// File: rtl/rho_rotate_dp.sv
// rho_rotate_dp: bit-serial rho stage, rotates each (row, column) lane along the page axis
// Ports: clk, rst (async active-low), start (accept data_in while idle), data_in (state in),
//        busy (run in progress), done (one-cycle pulse, data_out complete), data_out (rotated state)
module rho_rotate_dp #(
  parameter int NUM_ROW    = 5,
  parameter int NUM_COLUMN = 5,
  parameter int NUM_PAGE   = 64,
  parameter int NUM_CELLS  = NUM_ROW * NUM_COLUMN * NUM_PAGE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CELLS-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CELLS-1:0] data_out
);
  localparam int AW = $clog2(NUM_CELLS);
  localparam int IW = $clog2(NUM_ROW);
  localparam int JW = $clog2(NUM_COLUMN);
  localparam int KW = $clog2(NUM_PAGE);
  localparam int LW = $clog2(NUM_ROW * NUM_COLUMN);
  // lane offsets, row-major by y: entry y*5+x
  localparam logic [KW-1:0] ROT [25] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 r_state, w_next;
  logic [IW-1:0]          r_i;
  logic [JW-1:0]          r_j;
  logic [KW-1:0]          r_k;
  logic [NUM_CELLS-1:0]   r_snap, r_data_out;
  logic                   w_last_i, w_last_j, w_last_k;
  logic [LW-1:0]          w_lane;
  logic [KW:0]            w_diff;
  logic [KW-1:0]          w_src_k;
  logic [AW-1:0]          w_dst, w_src;
  assign w_last_i = r_i == IW'(NUM_ROW - 1);
  assign w_last_j = r_j == JW'(NUM_COLUMN - 1);
  assign w_last_k = r_k == KW'(NUM_PAGE - 1);
  assign w_lane   = LW'(int'(r_i) * NUM_COLUMN + int'(r_j));
  // 7-bit difference; dropping the top bit is the mod-64 wrap for k < R
  assign w_diff   = {1'b0, r_k} - {1'b0, ROT[w_lane]};
  assign w_src_k  = w_diff[KW-1:0];
  assign w_dst    = AW'(r_k) * AW'(NUM_ROW * NUM_COLUMN) + AW'(r_j) * AW'(NUM_ROW) + AW'(r_i);
  assign w_src    = AW'(w_src_k) * AW'(NUM_ROW * NUM_COLUMN) + AW'(r_j) * AW'(NUM_ROW) + AW'(r_i);
  assign busy     = r_state == RUN;
  assign done     = r_state == DONE;
  assign data_out = r_data_out;
  always_comb begin
    w_next = r_state == IDLE ? (start ? RUN : IDLE)
           : r_state == RUN  ? ((w_last_i && w_last_j && w_last_k) ? DONE : RUN)
           : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_snap     <= '0;
      r_data_out <= '0;
    end else if (r_state == IDLE && start) begin
      r_snap <= data_in;
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
    end else if (r_state == RUN) begin
      r_data_out[w_dst] <= r_snap[w_src];
      r_i <= w_last_i ? '0 : r_i + 1'b1;
      r_j <= w_last_i ? (w_last_j ? '0 : r_j + 1'b1) : r_j;
      r_k <= (w_last_i && w_last_j) ? (w_last_k ? '0 : r_k + 1'b1) : r_k;
    end
  end
endmodule

// File: tb/tb_rho_rotate_dp.sv
// tb_rho_rotate_dp: directed self-checking bench for rho_rotate_dp
module tb_rho_rotate_dp;
  localparam int N = 1600;
  logic         clk = 0;
  logic         rst = 0;
  logic         start = 0;
  logic [N-1:0] data_in = '0;
  logic         busy, done;
  logic [N-1:0] data_out;
  int tests = 0;
  int fails = 0;
  int first_done, n_done, n_busy;
  rho_rotate_dp dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .data_out(data_out)
  );
  always #5 clk = ~clk;
  function automatic logic [N-1:0] bits2(input int a, input int b);
    logic [N-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction
  function automatic int lowbit(input logic [N-1:0] v);
    for (int b = 0; b < N; b++) if (v[b]) return b;
    return -1;
  endfunction
  task automatic chk_int(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask
  task automatic chk_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0d bits set (lowest %0d, low word %h), expected %0d bits set (lowest %0d, low word %h)",
             tag, $countones(obs), lowbit(obs), obs[63:0], $countones(expv), lowbit(expv), expv[63:0]);
    end
  endtask
  // start edge is T; sample c is taken #1 after edge T+c-1
  task automatic run(input logic [N-1:0] din, input int inj);
    data_in = din;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    first_done = 0; n_done = 0; n_busy = 0;
    for (int c = 1; c <= 1620; c++) begin
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      if (c == inj) begin
        start = 1;
        data_in = '1;
      end else if (c == inj + 1) start = 0;
      @(posedge clk); #1;
    end
  endtask
  task automatic check_run(input string tag, input logic [N-1:0] expv);
    chk_int({tag, " done cycle"}, first_done, 1601);
    chk_int({tag, " done pulses"}, n_done, 1);
    chk_int({tag, " busy cycles"}, n_busy, 1600);
    chk_vec({tag, " data_out"}, data_out, expv);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_int("reset busy", int'(busy), 0);
    chk_int("reset done", int'(done), 0);
    chk_vec("reset data_out", data_out, '0);
    rst = 1;
    @(posedge clk); #1;
    run('0, 0);
    check_run("zeros", '0);
    run(bits2(30, -1), 0);
    check_run("bit30", bits2(55, -1));
    run(bits2(135, -1), 0);
    check_run("bit135 wrap", bits2(85, -1));
    run(bits2(1524, -1), 0);
    check_run("bit1524", bits2(274, -1));
    run(bits2(0, 1575), 0);
    check_run("lane00", bits2(0, 1575));
    run(bits2(30, -1), 500);
    check_run("restart ignored", bits2(55, -1));
    data_in = bits2(1524, -1);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (800) @(posedge clk);
    #2;
    chk_int("pre-reset busy", int'(busy), 1);
    rst = 0;
    #1;
    chk_int("async rst busy", int'(busy), 0);
    chk_int("async rst done", int'(done), 0);
    chk_vec("async rst data_out", data_out, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    chk_int("held rst busy", int'(busy), 0);
    @(posedge clk); #1;
    run(bits2(135, -1), 0);
    check_run("after reset", bits2(85, -1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rho_rotate_dp.md
Name: rho_rotate_dp

Overview:
- Bit-serial lane-rotation (rho) stage directly downstream of the column-parity stage.
- Consumes the full NUM_CELLS-bit state that the column-parity stage produces.
- Rotates each (row, column) lane along the page axis by a fixed per-lane offset and presents the rotated state on data_out for the next permutation stage.
- State bit addressing is shared with the column-parity stage: address = k*NUM_ROW*NUM_COLUMN + j*NUM_ROW + i, with i = row (y), j = column (x) and k = page (z).

Parameters:
- NUM_ROW, 5, rows per page (i range)
- NUM_COLUMN, 5, columns per page (j range)
- NUM_PAGE, 64, pages; lane length, and the rotation modulus
- NUM_CELLS, 1600, NUM_ROW*NUM_COLUMN*NUM_PAGE

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request to rotate data_in
- data_in  input  NUM_CELLS  state from the column-parity stage
- busy  output  1  high while the snapshot is being processed
- done  output  1  one-cycle pulse when data_out is complete
- data_out  output  NUM_CELLS  rotated state

Behaviour:
- Reset (rst low, asynchronous): FSM goes to IDLE. The i, j and k counters, the snapshot register, data_out, busy and done all clear to 0.
- FSM states: IDLE -> RUN -> DONE -> IDLE.
- IDLE: busy=0, done=0. On start=1 at edge T, data_in is latched into the snapshot register, the counters clear, and the FSM moves to RUN.
- RUN: busy=1. Each cycle one output bit is written at the current (i, j, k):
  - data_out[addr(i,j,k)] <= snap[addr(i, j, (k - R[j][i]) mod NUM_PAGE)].
- Counter order (same as the column-parity stage):
  - i increments every cycle and wraps at NUM_ROW.
  - j increments on i wrap and wraps at NUM_COLUMN.
  - k increments on j wrap.
  - On k wrap at NUM_PAGE the FSM moves to DONE.
- RUN lasts exactly NUM_CELLS (1600) cycles, edges T+1..T+1600.
- DONE: lasts one cycle (edge T+1601 state). busy=0, done=1. Next state is IDLE.
- Latency: start to done pulse is 1601 cycles.
- data_out holds its value from the end of one run until bits are overwritten in the next RUN. During RUN, data_out is partially updated; consumers sample it only on done.
- start while in RUN or DONE is ignored. There is no queuing.
- data_in changing after the start edge has no effect, because all reads use the snapshot.
- Rotation offsets R[x=j][y=i], fixed constants:
  - y=0: 0, 1, 62, 28, 27
  - y=1: 36, 44, 6, 55, 20
  - y=2: 3, 10, 43, 25, 39
  - y=3: 41, 45, 15, 21, 8
  - y=4: 18, 2, 61, 56, 14
  - (each row lists x=0..4)
- Page arithmetic: (k - R) is computed at 7 bits and reduced mod NUM_PAGE. No negative wrap is permitted, so k < R must map to k - R + 64.
- Equivalent statement: input bit at page k of lane (i,j) moves to page (k + R[j][i]) mod 64.
- Reset mid-RUN: everything clears immediately. A later start begins a fresh run from i=j=k=0.
- start asserted in the same cycle that DONE returns to IDLE is not accepted. It must be presented while in IDLE.

Test Plan:
- All-zero data_in, start pulse -> busy high for 1600 cycles, done pulse at cycle 1601, data_out = 0.
- data_in with only bit 30 set (i=0, j=1, k=1) -> after done, data_out has only bit 55 set (k=2; R=1).
- data_in with only bit 135 set (i=0, j=2, k=5) -> only bit 85 set (k=(5+62) mod 64 = 3, the wrap case).
- Only bit 1524 set (i=4, j=4, k=60; R=14) -> only bit 274 set (k=10). In a separate run, lane (0,0) bits 0 and 1575 map unchanged to 0 and 1575.
- Second start pulse at cycle 500 of a run, and data_in changed to all-ones mid-run -> exactly one done pulse at cycle 1601, result computed from the original snapshot, no second run.
- rst low at cycle 800 for 2 cycles -> data_out, busy and done go to 0 asynchronously. A new start with the bit-135 pattern -> done after 1601 cycles with only bit 85 set.
